// File: rtl/vga_scan_ctrl_pkg.sv
// Shared timing constants, flag bundle and helpers for the VGA raster generator.
// The VGA_* constants are the 640x480@60 defaults used by vga_scan_ctrl.
package vga_scan_ctrl_pkg;

   localparam int VGA_H_ACTIVE    = 640;
   localparam int VGA_H_FP        = 16;
   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_BP        = 48;
   localparam int VGA_V_ACTIVE    = 480;
   localparam int VGA_V_FP        = 10;
   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_BP        = 33;
   localparam int VGA_CLK_DIV     = 4;
   localparam int VGA_PIX_LATENCY = 2;

   localparam int CNT_W = 10;   // scan counter width, totals up to 1024

   // Per-pixel timing flags carried down the alignment pipe.
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } scan_flags_t;

   // Half-open window test lo <= v < hi. One extra bit so hi may reach 1024.
   function automatic logic in_window(input logic [CNT_W:0] v,
                                      input logic [CNT_W:0] lo,
                                      input logic [CNT_W:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register used to realign timing flags with the pixel path.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset; all stages load RST_VAL
//   en   - advance one stage (pixel tick)
//   d    - stage-0 input
//   q    - output DEPTH ticks later (DEPTH=0: q follows d combinationally)
module sync_delay_line #(
   parameter int                DEPTH   = 2,
   parameter int                WIDTH   = 3,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst, en};
         assign q = d;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] pipe;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
            end else if (en) begin
               pipe[0] <= d;
               for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign q = pipe[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster generator. Produces scan coordinates for the display sub-top,
// takes back the pixel colour it computes, and drives the VGA pins with
// HS/VS/blanking delayed to match that path's pixel latency.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   disp_value_RGB  - returned pixel colour {R,G,B} (4 bits each)
//   in_disp_area    - returned pixel lies inside the map area
//   scan_x, scan_y  - raw raster counters
//   pix_en          - one-clk pixel tick
//   frame_start     - one-clk pulse after the counters move to (0,0)
//   hs, vs          - latency-aligned syncs
//   r, g, b         - registered colour outputs
module vga_scan_ctrl
   import vga_scan_ctrl_pkg::*;
#(
   parameter int   H_ACTIVE    = VGA_H_ACTIVE,
   parameter int   H_FP        = VGA_H_FP,
   parameter int   H_SYNC      = VGA_H_SYNC,
   parameter int   H_BP        = VGA_H_BP,
   parameter int   V_ACTIVE    = VGA_V_ACTIVE,
   parameter int   V_FP        = VGA_V_FP,
   parameter int   V_SYNC      = VGA_V_SYNC,
   parameter int   V_BP        = VGA_V_BP,
   parameter int   CLK_DIV     = VGA_CLK_DIV,
   parameter int   PIX_LATENCY = VGA_PIX_LATENCY,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [11:0]      disp_value_RGB,
   input  logic             in_disp_area,
   output logic [CNT_W-1:0] scan_x,
   output logic [CNT_W-1:0] scan_y,
   output logic             pix_en,
   output logic             frame_start,
   output logic             hs,
   output logic             vs,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || PIX_LATENCY < 0) begin : g_bad_param
         $error("vga_scan_ctrl: illegal timing parameters");
      end
   endgenerate

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W:0]   H_ACT  = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   V_ACT  = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0]   HS_LO  = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0]   HS_HI  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0]   VS_LO  = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0]   VS_HI  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam scan_flags_t FLAGS_IDLE = '{active: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE};

   // ---------------- pixel tick ----------------
   // pix_en is registered from the next divider value so it is low in reset
   // and, with CLK_DIV=1, goes high from the first clk after release.
   logic [DIV_W-1:0] div_cnt, div_nxt;

   always_comb begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         pix_en  <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         pix_en  <= (div_nxt == DIV_LAST);
      end
   end

   // ---------------- raster counters ----------------
   // frame_start only fires on a real wrap to (0,0); the restart after reset
   // starts at (0,0) without passing through the wrap, so it never pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_x      <= '0;
         scan_y      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pix_en) begin
            if (scan_x == H_LAST) begin
               scan_x <= '0;
               if (scan_y == V_LAST) begin
                  scan_y      <= '0;
                  frame_start <= 1'b1;
               end else begin
                  scan_y <= scan_y + 1'b1;
               end
            end else begin
               scan_x <= scan_x + 1'b1;
            end
         end
      end
   end

   // ---------------- stage-0 flags and alignment ----------------
   scan_flags_t raw, dly;

   always_comb begin
      raw.active = ({1'b0, scan_x} < H_ACT) && ({1'b0, scan_y} < V_ACT);
      raw.hs     = in_window({1'b0, scan_x}, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      raw.vs     = in_window({1'b0, scan_y}, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end

   sync_delay_line #(
      .DEPTH   (PIX_LATENCY),
      .WIDTH   (3),
      .RST_VAL (FLAGS_IDLE)
   ) u_flag_dly (
      .clk (clk),
      .rst (rst),
      .en  (pix_en),
      .d   (raw),
      .q   (dly)
   );

   // ---------------- output registers ----------------
   // All pins update only on pix_en, so they can only change in the clk
   // after a tick; blanking forces black outside the visible area.
   logic [11:0] rgb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs  <= ~SYNC_ACTIVE;
         vs  <= ~SYNC_ACTIVE;
         rgb <= 12'h000;
      end else if (pix_en) begin
         hs  <= dly.hs;
         vs  <= dly.vs;
         rgb <= (dly.active && in_disp_area) ? disp_value_RGB : 12'h000;
      end
   end

   assign r = rgb[11:8];
   assign g = rgb[7:4];
   assign b = rgb[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a shrunken raster (15x8 totals) so
// whole frames fit in a short run. Instance a: CLK_DIV=4, PIX_LATENCY=2.
// Instance b: CLK_DIV=1, PIX_LATENCY=0.
// Raster: H 8/2/3/2 (hs low at x=10..12), V 4/1/2/1 (vs low at y=5..6).
module tb_vga_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [11:0] rgb_in;
   logic        area;

   logic [9:0] sx_a, sy_a, sx_b, sy_b;
   logic       pix_a, fs_a, hs_a, vs_a, pix_b, fs_b, hs_b, vs_b;
   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

   vga_scan_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(4), .PIX_LATENCY(2), .SYNC_ACTIVE(1'b0)
   ) dut_a (
      .clk(clk), .rst(rst_a), .disp_value_RGB(rgb_in), .in_disp_area(area),
      .scan_x(sx_a), .scan_y(sy_a), .pix_en(pix_a), .frame_start(fs_a),
      .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a)
   );

   vga_scan_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(1), .PIX_LATENCY(0), .SYNC_ACTIVE(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst_b), .disp_value_RGB(rgb_in), .in_disp_area(area),
      .scan_x(sx_b), .scan_y(sy_b), .pix_en(pix_b), .frame_start(fs_b),
      .hs(hs_b), .vs(vs_b), .r(r_b), .g(g_b), .b(b_b)
   );

   wire [11:0] col_a = {r_a, g_a, b_a};
   wire [11:0] col_b = {r_b, g_b, b_b};

   int errors = 0;
   int checks = 0;
   int ticks_a = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Advance to the negedge just after the next pixel-tick edge of dut_a.
   task automatic tick_a();
      int n = 0;
      while (!pix_a && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!pix_a) chk("tick_timeout", n, 0);
      @(negedge clk);
      ticks_a++;
   endtask

   typedef struct {
      int          tick;
      logic        area;
      logic [11:0] rgb;
      int          x, y;
      logic        hs, vs;
      logic [11:0] orgb;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n, p1, p2, rx, ry;
      int c_col, c_oth, c_hs, c_vs, c_fs;

      // After tick k the counters sit at position k, pins show position k-3.
      tbl[0]  = '{1,   1'b1, 12'hF0A, 1,  0, 1'b1, 1'b1, 12'h000};
      tbl[1]  = '{2,   1'b1, 12'hF0A, 2,  0, 1'b1, 1'b1, 12'h000};
      tbl[2]  = '{3,   1'b1, 12'hF0A, 3,  0, 1'b1, 1'b1, 12'hF0A};
      tbl[3]  = '{5,   1'b0, 12'hFFF, 5,  0, 1'b1, 1'b1, 12'h000};
      tbl[4]  = '{11,  1'b1, 12'hF0A, 11, 0, 1'b1, 1'b1, 12'h000};
      tbl[5]  = '{13,  1'b1, 12'hF0A, 13, 0, 1'b0, 1'b1, 12'h000};
      tbl[6]  = '{15,  1'b1, 12'hF0A, 0,  1, 1'b0, 1'b1, 12'h000};
      tbl[7]  = '{16,  1'b1, 12'hF0A, 1,  1, 1'b1, 1'b1, 12'h000};
      tbl[8]  = '{18,  1'b1, 12'h5A3, 3,  1, 1'b1, 1'b1, 12'h5A3};
      tbl[9]  = '{60,  1'b1, 12'h5A3, 0,  4, 1'b0, 1'b1, 12'h000};
      tbl[10] = '{78,  1'b1, 12'h5A3, 3,  5, 1'b1, 1'b0, 12'h000};
      tbl[11] = '{108, 1'b1, 12'h5A3, 3,  7, 1'b1, 1'b1, 12'h000};
      tbl[12] = '{123, 1'b1, 12'h0C1, 3,  0, 1'b1, 1'b1, 12'h0C1};

      rst_a = 1'b0; rst_b = 1'b0; area = 1'b0; rgb_in = 12'h000;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_scan_x", int'(sx_a), 0);
      chk("rst_scan_y", int'(sy_a), 0);
      chk("rst_pix_en", int'(pix_a), 0);
      chk("rst_frame_start", int'(fs_a), 0);
      chk("rst_hs", int'(hs_a), 1);
      chk("rst_vs", int'(vs_a), 1);
      chk("rst_rgb", int'(col_a), 0);
      chk("rst_b_pix_en", int'(pix_b), 0);
      chk("rst_b_misc", int'({sy_b, vs_b, fs_b, col_b}), int'({10'd0, 1'b1, 1'b0, 12'h000}));

      rst_a = 1'b1;
      n = 0;
      while (!pix_a && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("first_tick_delay", n, 3);

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         area   = tbl[i].area;
         rgb_in = tbl[i].rgb;
         while (ticks_a < tbl[i].tick) tick_a();
         chk($sformatf("v%0d_scan_x", i), int'(sx_a), tbl[i].x);
         chk($sformatf("v%0d_scan_y", i), int'(sy_a), tbl[i].y);
         chk($sformatf("v%0d_hs", i), int'(hs_a), int'(tbl[i].hs));
         chk($sformatf("v%0d_vs", i), int'(vs_a), int'(tbl[i].vs));
         chk($sformatf("v%0d_rgb", i), int'(col_a), int'(tbl[i].orgb));
      end

      // One full frame of pins with a constant in-area colour
      area = 1'b1; rgb_in = 12'hF0A;
      repeat (3) tick_a();
      c_col = 0; c_oth = 0; c_hs = 0; c_vs = 0; c_fs = 0;
      repeat (120) begin
         tick_a();
         if (col_a == 12'hF0A) c_col++;
         else if (col_a != 12'h000) c_oth++;
         if (!hs_a) c_hs++;
         if (!vs_a) c_vs++;
         if (fs_a) c_fs++;
      end
      chk("frame_colour_ticks", c_col, 32);
      chk("frame_other_colour", c_oth, 0);
      chk("frame_hs_low_ticks", c_hs, 24);
      chk("frame_vs_low_ticks", c_vs, 30);
      chk("frame_start_count", c_fs, 1);

      // frame_start width and period
      n = 0;
      while (!fs_a && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("fs_found", int'(fs_a), 1);
      @(negedge clk);
      chk("fs_width", int'(fs_a), 0);
      n = 1;
      while (!fs_a && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("fs_period_clks", n, 480);

      // Out-of-area pixels stay black; syncs unaffected
      area = 1'b0; rgb_in = 12'hFFF;
      repeat (3) tick_a();
      c_oth = 0; c_hs = 0; c_vs = 0;
      repeat (120) begin
         tick_a();
         if (col_a != 12'h000) c_oth++;
         if (!hs_a) c_hs++;
         if (!vs_a) c_vs++;
      end
      chk("noarea_rgb_nonzero", c_oth, 0);
      chk("noarea_hs_low_ticks", c_hs, 24);
      chk("noarea_vs_low_ticks", c_vs, 30);

      // Mid-frame asynchronous reset
      area = 1'b1; rgb_in = 12'hF0A;
      n = 0;
      while (!(sx_a == 10'd5 && sy_a == 10'd2) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_rgb", int'(col_a), 12'hF0A);
      rst_a = 1'b0;
      #1;
      chk("midrst_rgb", int'(col_a), 0);
      chk("midrst_hs", int'(hs_a), 1);
      chk("midrst_vs", int'(vs_a), 1);
      chk("midrst_scan", int'({sx_a, sy_a}), 0);
      chk("midrst_pix_en", int'(pix_a), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      n = 0; p1 = -1; p2 = -1; rx = -1; ry = -1;
      while (!fs_a && n < 1000) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            rx = int'(sx_a);
            ry = int'(sy_a);
         end
         if (pix_a && p1 < 0) p1 = n;
         else if (pix_a && p2 < 0) p2 = n;
      end
      chk("restart_x", rx, 0);
      chk("restart_y", ry, 0);
      chk("pix_en_first", p1, 3);
      chk("pix_en_second", p2, 7);
      chk("restart_fs_delay", n, 480);

      // CLK_DIV=1, PIX_LATENCY=0 instance
      @(negedge clk);
      rst_b = 1'b1;
      c_col = 0;
      repeat (40) begin
         @(negedge clk);
         if (pix_b) c_col++;
      end
      chk("b_pix_en_constant", c_col, 40);
      n = 0;
      while (sx_b != 10'd13 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("b_found_x13", int'(sx_b), 13);
      chk("b_hs_before_edge", int'(hs_b), 0);
      @(negedge clk);
      chk("b_hs_rise", int'(hs_b), 1);
      n = 0;
      while (!fs_b && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("b_fs_found", int'(fs_b), 1);
      n = 1;
      @(negedge clk);
      while (!fs_b && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("b_fs_period", n, 120);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
